// File: rtl/alu_mdu.sv
// Execute unit: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Results are registered and held in DONE until the consumer takes them.
module alu_mdu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_SLL, OP_SRL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_SRA, OP_RSV
  } op_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mul_q, neg_q, rneg_q;
  logic [WIDTH-1:0]   dvsr;
  logic [2*WIDTH-1:0] acc;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  logic               accept, is_md, is_div, sgn, dz, dovf;
  logic [WIDTH-1:0]   mag_a, mag_b, alu_lo;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sum, diff;
  logic [SHAMT_W-1:0] sh;

  always_comb begin
    accept  = in_valid & in_ready & ~abort;
    is_md   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_div  = (op == OP_DIV) || (op == OP_DIVU);
    sgn     = (op == OP_MULT) || (op == OP_DIV);
    dz      = is_div && (port_b == '0);
    dovf    = (op == OP_DIV) && (port_a == MIN) && (port_b == '1);
    mag_a   = (sgn && port_a[WIDTH-1]) ? -port_a : port_a;
    mag_b   = (sgn && port_b[WIDTH-1]) ? -port_b : port_b;
    sh      = port_a[SHAMT_W-1:0];
    sum     = port_a + port_b;
    diff    = port_a - port_b;
    alu_lo  = sum;
    alu_ovf = 1'b0;
    case (op)
      OP_SLL:  alu_lo = port_b << sh;
      OP_SRL:  alu_lo = port_b >> sh;
      OP_SRA:  alu_lo = $signed(port_b) >>> sh;
      OP_SUB: begin
        alu_lo  = diff;
        alu_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) && (diff[WIDTH-1] != port_a[WIDTH-1]);
      end
      OP_AND:  alu_lo = port_a & port_b;
      OP_OR:   alu_lo = port_a | port_b;
      OP_XOR:  alu_lo = port_a ^ port_b;
      OP_NOR:  alu_lo = ~(port_a | port_b);
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, $signed(port_a) < $signed(port_b)};
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, port_a < port_b};
      default: alu_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sum[WIDTH-1] != port_a[WIDTH-1]);
    endcase
  end

  // One iteration of either algorithm; acc = {upper, lower} halves.
  logic [WIDTH:0]     msum, rsh;
  logic [2*WIDTH-1:0] step_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo, fin_hi, quo, rem;

  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
    rsh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    step_nxt = {msum, acc[WIDTH-1:1]};
    if (!mul_q) begin
      if (rsh >= {1'b0, dvsr})
        step_nxt = {WIDTH'(rsh - {1'b0, dvsr}), acc[WIDTH-2:0], 1'b1};
      else
        step_nxt = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    fin_lo = mul_q ? prod[WIDTH-1:0]       : (neg_q ? -quo : quo);
    fin_hi = mul_q ? prod[2*WIDTH-1:WIDTH] : (rneg_q ? -rem : rem);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dvsr      <= '0;
      acc       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          overflow <= 1'b0;
          div_zero <= 1'b0;
          zero     <= 1'b0;
          negative <= 1'b0;
          if (is_md && !dz && !dovf) begin
            state  <= EXEC;
            cnt    <= '0;
            mul_q  <= !is_div;
            neg_q  <= sgn && (port_a[WIDTH-1] ^ port_b[WIDTH-1]);
            rneg_q <= sgn && port_a[WIDTH-1];
            dvsr   <= is_div ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
          end else begin
            state <= DONE;
            if (dz) begin
              result_lo <= '1;
              result_hi <= port_a;
              div_zero  <= 1'b1;
              negative  <= 1'b1;
            end else if (dovf) begin
              result_lo <= MIN;
              result_hi <= '0;
              overflow  <= 1'b1;
              negative  <= 1'b1;
            end else begin
              result_lo <= alu_lo;
              result_hi <= '0;
              overflow  <= alu_ovf;
              zero      <= (alu_lo == '0);
              negative  <= alu_lo[WIDTH-1];
            end
          end
        end
        EXEC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            state     <= DONE;
            result_lo <= fin_lo;
            result_hi <= fin_hi;
            zero      <= (fin_lo == '0);
            negative  <= fin_lo[WIDTH-1];
          end else begin
            acc <= step_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results are modelled on issue and compared on completion.
module tb_alu_mdu;
  logic        CLK = 0, nRST = 0, abort = 0, in_valid = 0, out_ready = 0;
  logic [3:0]  op = 0;
  logic [31:0] port_a = 0, port_b = 0;
  logic        in_ready, out_valid, zero, negative, overflow, div_zero;
  logic [31:0] result_lo, result_hi;

  alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .port_a(port_a), .port_b(port_b), .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .zero(zero), .negative(negative),
    .overflow(overflow), .div_zero(div_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] lo, hi;
    logic ovf, dz, zr, ng;
  } res_t;

  res_t q[$];
  res_t last;
  int checks = 0, failures = 0;

  function automatic res_t model(logic [3:0] o, logic [31:0] a, logic [31:0] b);
    res_t r;
    logic [63:0] p;
    logic [31:0] s;
    logic signed [31:0] sa, sb;
    r = '0; sa = a; sb = b;
    case (o)
      4'h0: r.lo = b << a[4:0];
      4'h1: r.lo = b >> a[4:0];
      4'h3: begin s = a - b; r.lo = s; r.ovf = (a[31] != b[31]) && (s[31] != a[31]); end
      4'h4: r.lo = a & b;
      4'h5: r.lo = a | b;
      4'h6: r.lo = a ^ b;
      4'h7: r.lo = ~(a | b);
      4'h8: r.lo = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: r.lo = (a < b) ? 32'd1 : 32'd0;
      4'hA: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r.lo = p[31:0]; r.hi = p[63:32];
      end
      4'hB: begin p = {32'd0, a} * {32'd0, b}; r.lo = p[31:0]; r.hi = p[63:32]; end
      4'hC: begin
        if (b == 0) begin r.lo = '1; r.hi = a; r.dz = 1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = a; r.ovf = 1; end
        else begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
      end
      4'hD: begin
        if (b == 0) begin r.lo = '1; r.hi = a; r.dz = 1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      4'hE: r.lo = sb >>> a[4:0];
      default: begin s = a + b; r.lo = s; r.ovf = (a[31] == b[31]) && (s[31] != a[31]); end
    endcase
    r.zr = (r.lo == 0);
    r.ng = r.lo[31];
    return r;
  endfunction

  function automatic res_t obs();
    res_t r;
    r.lo = result_lo; r.hi = result_hi; r.ovf = overflow; r.dz = div_zero; r.zr = zero; r.ng = negative;
    return r;
  endfunction

  task automatic start_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 200) begin @(negedge CLK); n++; end
    in_valid = 1; op = o; port_a = a; port_b = b;
    if (push) q.push_back(model(o, a, b));
    @(posedge CLK); #1;
    in_valid = 0; op = 4'($urandom); port_a = $urandom; port_b = $urandom;
  endtask

  task automatic wait_out(output int lat, output bit ir);
    lat = 0; ir = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir = 1;
      @(posedge CLK); #1; lat++;
    end
  endtask

  task automatic consume();
    @(negedge CLK); out_ready = 1;
    @(posedge CLK); #1; out_ready = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs() !== res_t'(0) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset got res=%h ir=%b ov=%b exp res=0 ir=1 ov=0", obs(), in_ready, out_valid);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops[12] = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'h2};
    logic [31:0] as[12]  = '{32'd31, 32'd8, 32'h8000_0000, 32'd5, 32'hF0F0_F0F0, 32'h0F00_0000,
                             32'hFFFF_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd9};
    logic [31:0] bs[12]  = '{32'd1, 32'h8000_0000, 32'd1, 32'd5, 32'hFF00_FF00, 32'h0000_00F0,
                             32'h0FF0_0FF0, 32'h0, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFF7};
    int lat; bit ir; res_t e;
    for (int i = 0; i < 12; i++) begin
      start_op(ops[i], as[i], bs[i], 1);
      wait_out(lat, ir);
      e = q.pop_front(); last = e;
      checks++;
      if (obs() !== e || lat != 0) begin
        failures++;
        $display("FAIL alu_op%h got %h lat=%0d exp %h lat=0", ops[i], obs(), lat, e);
      end
      consume();
    end
  endtask

  task automatic test_add_ovf();
    int lat; bit ir; res_t e;
    start_op(4'h2, 32'h7FFF_FFFF, 32'h1, 1);
    out_ready = 1;
    wait_out(lat, ir);
    e = q.pop_front(); last = e;
    checks++;
    if (obs() !== e || lat != 0 || result_lo !== 32'h8000_0000 || overflow !== 1'b1 || negative !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf got %h lat=%0d exp %h lat=0", obs(), lat, e);
    end
    @(posedge CLK); #1; out_ready = 0;
  endtask

  task automatic test_mult();
    int lat; bit ir; res_t e;
    start_op(4'hA, 32'hFFFF_FFFF, 32'h2, 1);
    checks++;
    if (overflow !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flag_clear got ovf=%b ir=%b exp ovf=0 ir=0", overflow, in_ready);
    end
    wait_out(lat, ir);
    e = q.pop_front(); last = e;
    checks++;
    if (obs() !== e || lat != 33 || ir || result_hi !== 32'hFFFF_FFFF || result_lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mult got %h lat=%0d ir_seen=%b exp %h lat=33 ir_seen=0", obs(), lat, ir, e);
    end
    consume();
  endtask

  task automatic test_mdu_mix();
    logic [3:0]  ops[6] = '{4'hC, 4'hD, 4'hB, 4'hC, 4'hA, 4'hD};
    logic [31:0] as[6]  = '{32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h0};
    logic [31:0] bs[6]  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 32'd3};
    int lat; bit ir; res_t e;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] o; logic [31:0] a, b;
      if (i < 6) begin o = ops[i]; a = as[i]; b = bs[i]; end
      else begin o = 4'hA + 4'($urandom_range(0, 3)); a = $urandom; b = $urandom | 32'h10; end
      start_op(o, a, b, 1);
      wait_out(lat, ir);
      e = q.pop_front(); last = e;
      checks++;
      if (obs() !== e || lat != 33) begin
        failures++;
        $display("FAIL mdu_op%h a=%h b=%h got %h lat=%0d exp %h lat=33", o, a, b, obs(), lat, e);
      end
      consume();
    end
  endtask

  task automatic test_div_special();
    logic [3:0]  ops[3] = '{4'hD, 4'hC, 4'hC};
    logic [31:0] as[3]  = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] bs[3]  = '{32'd0, 32'hFFFF_FFFF, 32'd0};
    int lat; bit ir; res_t e;
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], as[i], bs[i], 1);
      wait_out(lat, ir);
      e = q.pop_front(); last = e;
      checks++;
      if (obs() !== e || lat != 0) begin
        failures++;
        $display("FAIL div_special%0d got %h lat=%0d exp %h lat=0", i, obs(), lat, e);
      end
      consume();
    end
  endtask

  task automatic test_hold();
    int lat; bit ir; res_t e;
    start_op(4'hE, 32'd4, 32'h8000_0000, 1);
    wait_out(lat, ir);
    e = q.pop_front(); last = e;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      in_valid = 1; op = 4'h2; port_a = 32'd1; port_b = 32'd2;
      checks++;
      if (obs() !== e || out_valid !== 1'b1 || in_ready !== 1'b0 || result_lo !== 32'hF800_0000) begin
        failures++;
        $display("FAIL hold%0d got %h ov=%b ir=%b exp %h ov=1 ir=0", c, obs(), out_valid, in_ready, e);
      end
    end
    @(negedge CLK); in_valid = 0;
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_lo !== 32'hF800_0000) begin
      failures++;
      $display("FAIL hold_noaccept got ov=%b ir=%b lo=%h exp ov=0 ir=1 lo=f8000000", out_valid, in_ready, result_lo);
    end
  endtask

  task automatic test_abort();
    int lat; bit ir; res_t e;
    @(negedge CLK);
    in_valid = 1; abort = 1; op = 4'h2; port_a = 32'd3; port_b = 32'd4;
    @(posedge CLK); #1; in_valid = 0; abort = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_lo !== last.lo) begin
      failures++;
      $display("FAIL abort_vs_valid got ov=%b ir=%b lo=%h exp ov=0 ir=1 lo=%h", out_valid, in_ready, result_lo, last.lo);
    end
    start_op(4'hB, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (9) @(posedge CLK);
    @(negedge CLK); abort = 1;
    @(posedge CLK); #1; abort = 0;
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {result_lo, result_hi} !== {last.lo, last.hi}) begin
      failures++;
      $display("FAIL abort_mult got ov=%b ir=%b lo=%h hi=%h exp ov=0 ir=1 lo=%h hi=%h",
               out_valid, in_ready, result_lo, result_hi, last.lo, last.hi);
    end
    start_op(4'hD, 32'd1000, 32'd3, 0);
    repeat (5) @(posedge CLK);
    @(negedge CLK); nRST = 0; #1;
    checks++;
    if (obs() !== res_t'(0) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_div got %h ov=%b ir=%b exp 0 ov=0 ir=1", obs(), out_valid, in_ready);
    end
    @(negedge CLK); nRST = 1;
    start_op(4'hD, 32'd100, 32'd7, 1);
    wait_out(lat, ir);
    e = q.pop_front(); last = e;
    checks++;
    if (obs() !== e || lat != 33 || result_lo !== 32'd14 || result_hi !== 32'd2) begin
      failures++;
      $display("FAIL after_reset_divu got %h lat=%0d exp %h lat=33", obs(), lat, e);
    end
    consume();
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 test_reset();
    @(negedge CLK); nRST = 1;
    test_alu();
    test_add_ovf();
    test_mult();
    test_mdu_mix();
    test_div_special();
    test_hold();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
